instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The parameter ADDR_W SHALL default to 8 and sets the width of out_addr, the program word address.
REQ-002 The parameter FIFO_DEPTH SHALL default to 4, be a power of two >= 2, and set the number of buffered encoded words.
REQ-003 The clock port SHALL be clk, 1-bit input; all state updates on its rising edge.
REQ-004 The reset port SHALL be rst, 1-bit input, synchronous and active-high.
REQ-005 Port in_valid SHALL be a 1-bit input: the field bundle is valid.
REQ-006 Port in_ready SHALL be a 1-bit output: the encoder accepts the bundle this cycle.
REQ-007 Port in_op SHALL be a 2-bit input: 00 NOP, 01 ADD, 10 SUB, 11 illegal.
REQ-008 Ports in_rs1, in_rs2 and in_rd SHALL each be 4-bit inputs: source 1, source 2 and destination register numbers.
REQ-009 Port restart SHALL be a 1-bit input that rewinds the program address to 0.
REQ-010 Port out_valid SHALL be a 1-bit output: out_instr and out_addr are valid.
REQ-011 Port out_ready SHALL be a 1-bit input: the downstream instruction-memory writer takes the word.
REQ-012 Port out_instr SHALL be a 32-bit output carrying the encoded instruction word.
REQ-013 Port out_addr SHALL be an ADDR_W-bit output carrying the word address for out_instr.
REQ-014 Port illegal_cnt SHALL be an 8-bit output counting dropped illegal bundles.
REQ-015 Port err SHALL be a 1-bit output, a sticky illegal-op flag.

Function
REQ-016 The encoding SHALL be: [31:28] opcode, [27:24] rs1, [23:20] rs2, [19:16] rd, [15:0] = 0.
REQ-017 The opcodes SHALL be: ADD = 4'h2, SUB = 4'h4, NOP = 4'h0.
REQ-018 A NOP SHALL encode as 32'h0000_0000 regardless of the register inputs.
REQ-019 A bundle SHALL be accepted when in_valid && in_ready; in_ready SHALL equal !fifo_full, with no combinational dependence on out_ready.
REQ-020 An accepted legal bundle SHALL be encoded and written into the FIFO in the accept cycle.
REQ-021 out_valid SHALL assert the next cycle when the FIFO was empty, giving 1-cycle latency with no bypass.
REQ-022 An accepted illegal bundle (in_op = 11) SHALL be consumed and not written to the FIFO.
REQ-023 An illegal bundle SHALL increment illegal_cnt, saturating at 255, and set err, which stays set until rst.
REQ-024 out_valid SHALL equal !fifo_empty, and out_instr SHALL show the FIFO head.
REQ-025 Once out_valid is high, out_instr and out_addr SHALL hold stable until out_valid && out_ready.
REQ-026 The FIFO SHALL preserve acceptance order: legal words are emitted in order, with no loss or duplication.
REQ-027 A simultaneous push and pop SHALL leave the occupancy unchanged, and is legal at any non-full level.
REQ-028 When the FIFO is full, in_ready SHALL be 0 even if out_ready is 1 that cycle.
REQ-029 The address counter SHALL drive out_addr and increment by 1 on each out_valid && out_ready.
REQ-030 The address counter SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-031 When restart is 1, the address counter SHALL be 0 on the next cycle, taking priority over a coincident output handshake.
REQ-032 restart SHALL NOT alter FIFO contents, illegal_cnt or err.
REQ-033 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 Full and empty SHALL be distinguished by an occupancy count of FIFO_DEPTH vs 0.

Reset
REQ-035 When rst is 1 at a clock edge, the FIFO SHALL empty and out_valid SHALL be 0 next cycle.
REQ-036 After rst, in_ready SHALL be 1, out_addr 0, illegal_cnt 0, err 0, and out_instr 32'h0.
REQ-037 rst SHALL override all other inputs, including mid-burst, when full, and coincident with restart.
REQ-038 Words in flight at rst SHALL be discarded.

Verification
REQ-039 The bench SHALL cover a single ADD: rst; push op=01, rs1=3, rs2=5, rd=7 with out_ready=1 -> next cycle out_valid=1, out_instr=32'h2357_0000, out_addr=0; the following cycle out_valid=0 and the address is 1.
REQ-040 The bench SHALL cover a mixed stream: push SUB (1,2,9), NOP (f,f,f), ADD (0,0,1) -> out_instr sequence 32'h4129_0000, 32'h0000_0000, 32'h2001_0000 at addresses 0, 1, 2.
REQ-041 The bench SHALL cover backpressure: out_ready=0, push 5 legal bundles -> in_ready drops after the 4th accept, and the 5th is held; then set out_ready=1 -> all 5 words are emitted in order with stable out_instr while stalled.
REQ-042 The bench SHALL cover illegal ops: push op=11 three times, interleaved with ADD -> only the ADDs are emitted at consecutive addresses, illegal_cnt=3, err=1; after 300 illegal ops illegal_cnt=255.
REQ-043 The bench SHALL cover wrap and restart: with ADDR_W=8, emit 257 words -> the 257th is at out_addr=0; pulse restart during an output handshake at address 5 -> the next word is at address 0.
REQ-044 The bench SHALL cover reset mid-operation: FIFO holds 3 words, assert rst -> next cycle out_valid=0, in_ready=1, out_addr=0, err=0, and no stale word appears afterwards.

Source files
------------

// File: rtl/instr_encoder.sv
// Field-bundle to 32-bit instruction encoder with an output FIFO and a word-address
// counter for an instruction-memory writer. Illegal ops are consumed, counted and flagged.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [3:0]        in_rd,
  input  logic              restart,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        illegal_cnt,
  output logic              err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  localparam logic [3:0] OPC_ADD = 4'h2;
  localparam logic [3:0] OPC_SUB = 4'h4;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, and in_ready depends only on FIFO occupancy (not on out_ready).

  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       enc_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              is_illegal;
  logic              push;
  logic              pop;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign in_ready   = !fifo_full;
  assign out_valid  = !fifo_empty;
  assign accept     = in_valid && in_ready;
  assign is_illegal = (in_op == 2'b11);
  assign push       = accept && !is_illegal;
  assign pop        = out_valid && out_ready;

  always_comb begin
    enc_word = 32'h0;
    unique case (in_op)
      OP_ADD:  enc_word = {OPC_ADD, in_rs1, in_rs2, in_rd, 16'h0};
      OP_SUB:  enc_word = {OPC_SUB, in_rs1, in_rs2, in_rd, 16'h0};
      OP_NOP:  enc_word = 32'h0;
      default: enc_word = 32'h0;
    endcase
  end

  // Storage is not reset; the empty FIFO masks the head so out_instr reads 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Restart wins over a coincident handshake; the counter wraps silently.
  always_ff @(posedge clk) begin
    if (rst || restart) addr_q <= '0;
    else if (pop)       addr_q <= addr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= 8'h0;
      err         <= 1'b0;
    end else if (accept && is_illegal) begin
      if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'h1;
      err <= 1'b1;
    end
  end

  assign out_instr = fifo_empty ? 32'h0 : mem[rd_ptr];
  assign out_addr  = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder: the driver pushes expected words into a
// scoreboard queue at acceptance, and a negedge monitor pops and compares on each handshake.
module tb_instr_encoder;

  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [3:0]        in_rs1;
  logic [3:0]        in_rs2;
  logic [3:0]        in_rd;
  logic              restart;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        illegal_cnt;
  logic              err;

  instr_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .restart(restart),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .illegal_cnt(illegal_cnt), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model state ----------------
  logic [31:0] exp_q[$];
  int          model_addr = 0;
  int          model_ill  = 0;
  logic        model_err  = 1'b0;
  logic        mon_en     = 1'b0;
  int          hs_cnt     = 0;
  int          last_addr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding straight from the field layout: opcode*2^28 + rs1*2^24 + rs2*2^20 + rd*2^16.
  function automatic logic [31:0] model_encode(input int op, input int rs1, input int rs2, input int rd);
    int opc;
    if (op == 1)      opc = 2;
    else if (op == 2) opc = 4;
    else              return 32'h0;
    return 32'(opc * (1 << 28) + rs1 * (1 << 24) + rs2 * (1 << 20) + rd * (1 << 16));
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready",    {31'b0, in_ready},  {31'b0, exp_q.size() != FIFO_DEPTH});
      check("out_valid",   {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      check("out_addr",    32'(out_addr),      32'(model_addr));
      check("illegal_cnt", 32'(illegal_cnt),   32'(model_ill));
      check("err",         {31'b0, err},       {31'b0, model_err});
      if (rst) begin
        exp_q.delete();
        model_addr = 0;
        model_ill  = 0;
        model_err  = 1'b0;
      end else begin
        logic hs;
        hs = out_valid && out_ready && (exp_q.size() != 0);
        if (hs) begin
          check("out_instr", out_instr, exp_q[0]);
          last_addr = 32'(out_addr);
          hs_cnt++;
          void'(exp_q.pop_front());
        end
        if (restart) model_addr = 0;
        else if (hs) model_addr = (model_addr + 1) % (1 << ADDR_W);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; restart = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push(input int op, input int rs1, input int rs2, input int rd);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_op = 2'(op); in_rs1 = 4'(rs1); in_rs2 = 4'(rs2); in_rd = 4'(rd);
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL push_timeout: bundle not accepted within 200 cycles at %0t", $time);
    end else if (op == 3) begin
      if (model_ill < 255) model_ill++;
      model_err = 1'b1;
    end else begin
      exp_q.push_back(model_encode(op, rs1, rs2, rd));
    end
  endtask

  task automatic drain();
    int c;
    out_ready = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
    end
  endtask

  task automatic rand_push();
    int op;
    op = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
    push(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs0;
    logic [31:0] held;
    logic        found;
    logic        rand_done;
    in_valid = 1'b0; in_op = 2'b00; in_rs1 = 4'h0; in_rs2 = 4'h0; in_rd = 4'h0;
    restart = 1'b0; out_ready = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'h1);
    check("reset_out_instr", out_instr, 32'h0);
    @(posedge clk); #1;

    // Single ADD
    do_reset();
    push(1, 3, 5, 7);
    @(negedge clk);
    check("add_valid", {31'b0, out_valid}, 32'h1);
    check("add_instr", out_instr, 32'h2357_0000);
    check("add_addr", 32'(out_addr), 32'h0);
    @(negedge clk);
    check("add_after_valid", {31'b0, out_valid}, 32'h0);
    check("add_after_addr", 32'(out_addr), 32'h1);
    @(posedge clk); #1;

    // Mixed stream SUB, NOP, ADD
    do_reset();
    push(2, 1, 2, 9);
    push(0, 15, 15, 15);
    push(1, 0, 0, 1);
    drain();
    check("mixed_last_addr", 32'(last_addr), 32'h2);

    // Backpressure: four fill the FIFO, the fifth waits until out_ready rises
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1, i, i + 1, i + 2);
    @(negedge clk);
    check("bp_full_in_ready", {31'b0, in_ready}, 32'h0);
    held = out_instr;
    fork
      push(2, 9, 8, 7);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_stable_instr", out_instr, held);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal ops interleaved with ADDs, then saturation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(3, 1, 1, 1);
      push(1, i, 0, 0);
    end
    drain();
    @(negedge clk);
    check("ill_cnt3", 32'(illegal_cnt), 32'd3);
    check("ill_err", {31'b0, err}, 32'h1);
    check("ill_addr", 32'(out_addr), 32'd3);
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) push(3, 0, 0, 0);
    @(negedge clk);
    check("ill_sat", 32'(illegal_cnt), 32'd255);
    @(posedge clk); #1;

    // Address wrap: the 257th word lands at address 0
    do_reset();
    hs0 = hs_cnt;
    for (int i = 0; i < 257; i++) push(1, i % 16, (i / 16) % 16, 1);
    drain();
    check("wrap_count", 32'(hs_cnt - hs0), 32'd257);
    check("wrap_addr", 32'(last_addr), 32'h0);

    // Restart coincident with the handshake at address 5
    do_reset();
    found = 1'b0;
    fork
      for (int i = 0; i < 12; i++) push(2, i, 3, 4);
      begin
        for (int c = 0; c < 100 && !found; c++) begin
          @(posedge clk); #1;
          if (out_valid && out_addr == 8'd5) begin
            found = 1'b1;
            restart = 1'b1;
            @(posedge clk); #1;
            restart = 1'b0;
            @(negedge clk);
            check("restart_addr", 32'(out_addr), 32'h0);
          end
        end
        if (!found) begin
          tests++; fails++;
          $display("FAIL restart_timeout: address 5 never presented, expected within 100 cycles");
        end
      end
    join
    drain();

    // Reset mid-operation with three words buffered and err set
    do_reset();
    out_ready = 1'b0;
    push(3, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(1, 5, 6, i);
    do_reset();
    @(negedge clk);
    check("rst_mid_valid", {31'b0, out_valid}, 32'h0);
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_mid_err", {31'b0, err}, 32'h0);
    check("rst_mid_instr", out_instr, 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and restarts
    do_reset();
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) rand_push();
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
        restart   = ($urandom_range(0, 49) == 0);
      end
    join
    restart = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
